// File: rtl/dump_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dump_sequencer_pkg : state/section encodings and word-size constants for the debug dump path
// Rev 1.0
// ----------------------------------------------------------------------------
package dump_sequencer_pkg;

    localparam int c_bits_size_dflt     = 32;
    localparam int c_size_trama_dflt    = 8;
    localparam int c_n_regs_dflt        = 32;
    localparam int c_size_mem_data_dflt = 16;

    function automatic int bytes_per_word(input int bits_size, input int size_trama);
        return bits_size / size_trama;
    endfunction

    localparam int c_bytes_per_word = bytes_per_word(c_bits_size_dflt, c_size_trama_dflt);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_LATCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_TX  = 3'd4,
        ST_NEXT     = 3'd5,
        ST_FINISH   = 3'd6
    } dump_state_t;

    typedef enum logic [1:0] {
        SEC_PC    = 2'd0,
        SEC_COUNT = 2'd1,
        SEC_REGS  = 2'd2,
        SEC_MEM   = 2'd3
    } dump_section_t;

endpackage
`default_nettype wire

// File: rtl/dump_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dump_sequencer_if : start/done, source-data and UART-frame signals of the dump sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface dump_sequencer_if #(
    parameter int BITS_SIZE  = 32,
    parameter int SIZE_TRAMA = 8,
    parameter int N_REGS     = 32
);
    logic                      i_start;
    logic [BITS_SIZE-1:0]      i_mips_pc;
    logic [BITS_SIZE-1:0]      i_clk_count;
    logic [BITS_SIZE-1:0]      i_data_register;
    logic [BITS_SIZE-1:0]      i_data_mem;
    logic                      i_tx_done;
    logic                      o_tx_start;
    logic [SIZE_TRAMA-1:0]     o_tx_data;
    logic [$clog2(N_REGS)-1:0] o_select_addr_registers;
    logic [BITS_SIZE-1:0]      o_select_addr_memdata;
    logic                      o_busy;
    logic                      o_done;

    // master: debug unit / UART side that requests the dump
    modport master (
        output i_start, i_mips_pc, i_clk_count, i_data_register, i_data_mem, i_tx_done,
        input  o_tx_start, o_tx_data, o_select_addr_registers, o_select_addr_memdata,
               o_busy, o_done
    );

    modport slave (
        input  i_start, i_mips_pc, i_clk_count, i_data_register, i_data_mem, i_tx_done,
        output o_tx_start, o_tx_data, o_select_addr_registers, o_select_addr_memdata,
               o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/dump_sequencer_word_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dump_sequencer_word_serializer : splits one word into frames, most-significant frame first
// Rev 1.0
// ----------------------------------------------------------------------------
module dump_sequencer_word_serializer
    import dump_sequencer_pkg::*;
#(
    parameter int BITS_SIZE  = c_bits_size_dflt,
    parameter int SIZE_TRAMA = c_size_trama_dflt
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    input  wire logic                  i_load,
    input  wire logic                  i_shift,
    input  wire logic [BITS_SIZE-1:0]  i_word,
    output logic      [SIZE_TRAMA-1:0] o_top_byte,
    output logic                       o_last_byte
);
    localparam int c_bpw   = bytes_per_word(BITS_SIZE, SIZE_TRAMA);
    localparam int c_cnt_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_bpw - 1);

    logic [BITS_SIZE-1:0] r_shift;
    logic [c_cnt_w-1:0]   r_byte_idx;

    // The counter saturates at the last byte so a stray shift can never run past the word.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_shift    <= '0;
            r_byte_idx <= '0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_byte_idx <= '0;
        end else if (i_shift && (r_byte_idx != c_last_idx)) begin
            r_shift    <= r_shift << SIZE_TRAMA;
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

    assign o_top_byte  = r_shift[BITS_SIZE-1 -: SIZE_TRAMA];
    assign o_last_byte = (r_byte_idx == c_last_idx);

endmodule
`default_nettype wire

// File: rtl/dump_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dump_sequencer : streams PC, cycle count, register bank and data memory out as UART frames
// Rev 1.0
// ----------------------------------------------------------------------------
module dump_sequencer
    import dump_sequencer_pkg::*;
#(
    parameter int BITS_SIZE     = c_bits_size_dflt,
    parameter int SIZE_TRAMA    = c_size_trama_dflt,
    parameter int N_REGS        = c_n_regs_dflt,
    parameter int SIZE_MEM_DATA = c_size_mem_data_dflt
) (
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    dump_sequencer_if.slave bus
);
    localparam int c_reg_w  = $clog2(N_REGS);
    localparam int c_word_w = $clog2((N_REGS > SIZE_MEM_DATA) ? N_REGS : SIZE_MEM_DATA);
    localparam logic [c_word_w-1:0] c_last_reg = c_word_w'(N_REGS - 1);
    localparam logic [c_word_w-1:0] c_last_mem = c_word_w'(SIZE_MEM_DATA - 1);

    dump_state_t           r_state;
    dump_section_t         r_section;
    logic [c_word_w-1:0]   r_word;
    logic                  r_tx_start;
    logic [SIZE_TRAMA-1:0] r_tx_data;
    logic [c_reg_w-1:0]    r_sel_reg;
    logic [BITS_SIZE-1:0]  r_sel_mem;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_last_byte;
    logic [SIZE_TRAMA-1:0] w_top_byte;
    logic [BITS_SIZE-1:0]  w_word_in;
    logic [c_word_w-1:0]   w_word_inc;

    assign w_load     = (r_state == ST_LATCH);
    assign w_shift    = (r_state == ST_NEXT) && !w_last_byte;
    assign w_word_inc = r_word + 1'b1;

    always_comb begin
        w_word_in = bus.i_mips_pc;
        case (r_section)
            SEC_COUNT: w_word_in = bus.i_clk_count;
            SEC_REGS:  w_word_in = bus.i_data_register;
            SEC_MEM:   w_word_in = bus.i_data_mem;
            default:   w_word_in = bus.i_mips_pc;
        endcase
    end

    dump_sequencer_word_serializer #(
        .BITS_SIZE  (BITS_SIZE),
        .SIZE_TRAMA (SIZE_TRAMA)
    ) u_serializer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_shift     (w_shift),
        .i_word      (w_word_in),
        .o_top_byte  (w_top_byte),
        .o_last_byte (w_last_byte)
    );

    // Addresses are updated on the way into SET_ADDR so the bank/memory read latency
    // has elapsed by the time LATCH samples the data.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_section  <= SEC_PC;
            r_word     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_sel_reg  <= '0;
            r_sel_mem  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_busy    <= 1'b1;
                        r_section <= SEC_PC;
                        r_word    <= '0;
                        r_state   <= ST_SET_ADDR;
                    end
                end
                ST_SET_ADDR: r_state <= ST_LATCH;
                ST_LATCH:    r_state <= ST_SEND;
                ST_SEND: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= w_top_byte;
                    r_state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!w_last_byte) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_state <= ST_SET_ADDR;
                        case (r_section)
                            SEC_PC: r_section <= SEC_COUNT;
                            SEC_COUNT: begin
                                r_section <= SEC_REGS;
                                r_word    <= '0;
                                r_sel_reg <= '0;
                            end
                            SEC_REGS: begin
                                if (r_word == c_last_reg) begin
                                    r_section <= SEC_MEM;
                                    r_word    <= '0;
                                    r_sel_mem <= '0;
                                end else begin
                                    r_word    <= w_word_inc;
                                    r_sel_reg <= w_word_inc[c_reg_w-1:0];
                                end
                            end
                            default: begin
                                if (r_word == c_last_mem) begin
                                    r_state <= ST_FINISH;
                                end else begin
                                    r_word    <= w_word_inc;
                                    r_sel_mem <= BITS_SIZE'(w_word_inc);
                                end
                            end
                        endcase
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_tx_start              = r_tx_start;
    assign bus.o_tx_data               = r_tx_data;
    assign bus.o_select_addr_registers = r_sel_reg;
    assign bus.o_select_addr_memdata   = r_sel_mem;
    assign bus.o_busy                  = r_busy;
    assign bus.o_done                  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dump_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dump_sequencer : randomized dumps checked against a byte-stream model of the dump
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dump_sequencer;
    localparam int BITS_SIZE     = 32;
    localparam int SIZE_TRAMA    = 8;
    localparam int N_REGS        = 32;
    localparam int SIZE_MEM_DATA = 16;
    localparam int BPW           = BITS_SIZE / SIZE_TRAMA;
    localparam int TOTAL         = (2 + N_REGS + SIZE_MEM_DATA) * BPW;
    localparam int MEM_AW        = $clog2(SIZE_MEM_DATA);
    localparam int DONE_BOUND    = 6;

    logic i_clk;
    logic i_reset;

    dump_sequencer_if #(.BITS_SIZE(BITS_SIZE), .SIZE_TRAMA(SIZE_TRAMA), .N_REGS(N_REGS)) bus ();

    dump_sequencer #(
        .BITS_SIZE     (BITS_SIZE),
        .SIZE_TRAMA    (SIZE_TRAMA),
        .N_REGS        (N_REGS),
        .SIZE_MEM_DATA (SIZE_MEM_DATA)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    logic [BITS_SIZE-1:0] regs [N_REGS];
    logic [BITS_SIZE-1:0] mem  [SIZE_MEM_DATA];

    // register bank and data memory: synchronous read, one cycle of latency
    always @(posedge i_clk) begin
        bus.i_data_register <= regs[bus.o_select_addr_registers];
        bus.i_data_mem      <= mem[bus.o_select_addr_memdata[MEM_AW-1:0]];
    end

    // UART model: acknowledges each frame after a delay, optionally injects stray acks
    bit fixed_delay;
    bit spurious_en;
    initial begin
        int countdown;
        countdown = 0;
        bus.i_tx_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            bus.i_tx_done = 1'b0;
            if (!i_reset) begin
                countdown = 0;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) bus.i_tx_done = 1'b1;
            end else if (bus.o_tx_start) begin
                countdown = fixed_delay ? 10 : int'($urandom_range(1, 6));
            end else if (spurious_en && ($urandom_range(0, 3) == 0)) begin
                bus.i_tx_done = 1'b1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] cap_q [$];
    bit         model_active = 1'b0;
    bit         outstanding  = 1'b0;
    bit         rst_pending  = 1'b0;
    bit         final_seen   = 1'b0;
    bit         literal_mode = 1'b0;
    int         exp_idx      = 0;
    int         tx_done_cnt  = 0;
    int         final_cyc    = 0;
    int         cyc          = 0;
    int         reg_hold     = 0;
    int         mem_hold     = 0;
    int         dumps_done   = 0;
    logic [7:0] cur_byte     = 8'h00;

    logic [7:0] lit_head  [8] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h2A};
    logic [7:0] lit_r0    [4] = '{8'h11, 8'h11, 8'h00, 8'h00};
    logic [7:0] lit_r31   [4] = '{8'h11, 8'h11, 8'h00, 8'h1F};
    logic [7:0] lit_mlast [4] = '{8'hA0, 8'h00, 8'h00, 8'h0F};

    task automatic push_word(input logic [BITS_SIZE-1:0] w);
        for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(w[b*SIZE_TRAMA +: SIZE_TRAMA]);
    endtask

    always @(negedge i_clk) begin
        int w;
        int er;
        int em;
        cyc++;
        if (rst_pending) begin
            chk("rst_busy",     32'(bus.o_busy), 0);
            chk("rst_tx_start", 32'(bus.o_tx_start), 0);
            chk("rst_done",     32'(bus.o_done), 0);
            chk("rst_tx_data",  32'(bus.o_tx_data), 0);
            chk("rst_sel_reg",  32'(bus.o_select_addr_registers), 0);
            chk("rst_sel_mem",  32'(bus.o_select_addr_memdata), 0);
            rst_pending = 1'b0;
        end
        if (!i_reset) begin
            model_active = 1'b0;
            outstanding  = 1'b0;
            final_seen   = 1'b0;
            reg_hold     = 0;
            mem_hold     = 0;
            rst_pending  = 1'b1;
        end else if (model_active) begin
            if (bus.o_tx_start) begin
                chk("tx_no_overlap", 32'(outstanding), 0);
                if (exp_idx < TOTAL) begin
                    chk($sformatf("byte%0d", exp_idx), 32'(bus.o_tx_data), 32'(exp_q[exp_idx]));
                    w = exp_idx / BPW;
                    if (w < 2)                er = reg_hold;
                    else if (w < 2 + N_REGS)  er = w - 2;
                    else                      er = N_REGS - 1;
                    em = (w < 2 + N_REGS) ? mem_hold : (w - 2 - N_REGS);
                    chk($sformatf("sel_reg@byte%0d", exp_idx), 32'(bus.o_select_addr_registers), er);
                    chk($sformatf("sel_mem@byte%0d", exp_idx), 32'(bus.o_select_addr_memdata), em);
                    cap_q.push_back(bus.o_tx_data);
                end else begin
                    chk("tx_start_count", exp_idx + 1, TOTAL);
                end
                exp_idx++;
                outstanding = 1'b1;
                cur_byte    = bus.o_tx_data;
            end else if (outstanding) begin
                chk("tx_data_hold", 32'(bus.o_tx_data), 32'(cur_byte));
            end
            if (bus.i_tx_done && outstanding && !bus.o_tx_start) begin
                outstanding = 1'b0;
                tx_done_cnt++;
                if (tx_done_cnt == TOTAL) begin
                    final_seen = 1'b1;
                    final_cyc  = cyc;
                end
            end
            if (bus.o_done) begin
                chk("done_frames",     exp_idx, TOTAL);
                chk("done_after_last", 32'(final_seen), 1);
                chk("done_latency_ok", 32'((cyc - final_cyc) <= DONE_BOUND), 1);
                chk("done_busy_low",   32'(bus.o_busy), 0);
                if (literal_mode) begin
                    for (int i = 0; i < 8; i++) chk($sformatf("lit_head%0d", i), 32'(cap_q[i]), 32'(lit_head[i]));
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("lit_r0_%0d", i),    32'(cap_q[8 + i]),   32'(lit_r0[i]));
                        chk($sformatf("lit_r31_%0d", i),   32'(cap_q[132 + i]), 32'(lit_r31[i]));
                        chk($sformatf("lit_mlast_%0d", i), 32'(cap_q[196 + i]), 32'(lit_mlast[i]));
                    end
                    chk("lit_frames", cap_q.size(), 200);
                end
                model_active = 1'b0;
                reg_hold     = N_REGS - 1;
                mem_hold     = SIZE_MEM_DATA - 1;
                dumps_done++;
            end else begin
                chk("busy_high", 32'(bus.o_busy), 1);
                if (final_seen && ((cyc - final_cyc) > DONE_BOUND)) begin
                    chk("done_missing", cyc - final_cyc, DONE_BOUND);
                    model_active = 1'b0;
                end
            end
        end else begin
            chk("idle_tx_start", 32'(bus.o_tx_start), 0);
            chk("idle_busy",     32'(bus.o_busy), 0);
            chk("idle_done",     32'(bus.o_done), 0);
            if (bus.i_start) begin
                exp_q.delete();
                cap_q.delete();
                push_word(bus.i_mips_pc);
                push_word(bus.i_clk_count);
                for (int k = 0; k < N_REGS; k++)        push_word(regs[k]);
                for (int k = 0; k < SIZE_MEM_DATA; k++) push_word(mem[k]);
                model_active = 1'b1;
                outstanding  = 1'b0;
                final_seen   = 1'b0;
                exp_idx      = 0;
                tx_done_cnt  = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge i_clk); #1;
        bus.i_start = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic randomize_data();
        bus.i_mips_pc   = $urandom;
        bus.i_clk_count = $urandom;
        for (int k = 0; k < N_REGS; k++)        regs[k] = $urandom;
        for (int k = 0; k < SIZE_MEM_DATA; k++) mem[k]  = $urandom;
    endtask

    task automatic wait_dumps(input int n);
        int budget;
        budget = 0;
        while (dumps_done < n) begin
            @(posedge i_clk);
            budget++;
            if (budget > 10000) begin
                $display("FAIL wait_done: dumps=%0d required=%0d within 10000 cycles", dumps_done, n);
                $fatal(1, "dump did not complete");
            end
        end
    endtask

    task automatic wait_bytes(input int n);
        int budget;
        budget = 0;
        while (exp_idx < n) begin
            @(posedge i_clk);
            budget++;
            if (budget > 10000) begin
                $display("FAIL wait_bytes: frames=%0d required=%0d within 10000 cycles", exp_idx, n);
                $fatal(1, "frames did not arrive");
            end
        end
    endtask

    initial begin
        i_reset         = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_mips_pc   = '0;
        bus.i_clk_count = '0;
        fixed_delay     = 1'b1;
        spurious_en     = 1'b0;
        for (int k = 0; k < N_REGS; k++)        regs[k] = 32'h1111_0000 + k;
        for (int k = 0; k < SIZE_MEM_DATA; k++) mem[k]  = 32'hA000_0000 | k;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1;
        repeat (3) @(posedge i_clk);

        // directed dump with known contents and a fixed 10-cycle UART
        bus.i_mips_pc   = 32'h0000_0010;
        bus.i_clk_count = 32'h0000_002A;
        literal_mode    = 1'b1;
        pulse_start();
        wait_dumps(1);
        literal_mode = 1'b0;
        repeat (4) @(posedge i_clk);

        // random data, random UART latency, stray acks and a re-start mid-dump
        randomize_data();
        fixed_delay = 1'b0;
        spurious_en = 1'b1;
        pulse_start();
        wait_bytes(50);
        pulse_start();
        wait_dumps(2);
        repeat (4) @(posedge i_clk);

        // abort with reset during frame 70, then a fresh dump
        randomize_data();
        pulse_start();
        wait_bytes(70);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        randomize_data();
        pulse_start();
        wait_dumps(3);
        repeat (4) @(posedge i_clk);

        randomize_data();
        pulse_start();
        wait_dumps(4);
        repeat (5) @(posedge i_clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameter BITS_SIZE, default 32, MIPS word width; SHALL be a multiple of SIZE_TRAMA.
REQ-002 Parameter SIZE_TRAMA, default 8, UART frame width.
REQ-003 Parameter N_REGS, default 32, register-bank entries dumped.
REQ-004 Parameter SIZE_MEM_DATA, default 16, data-memory words dumped.
REQ-005 i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-low.
REQ-007 i_start  in  1  one-cycle pulse requesting a full dump.
REQ-008 i_mips_pc  in  BITS_SIZE  current MIPS PC.
REQ-009 i_clk_count  in  BITS_SIZE  executed-cycle counter.
REQ-010 i_data_register  in  BITS_SIZE  bank value at o_select_addr_registers, valid one cycle after the address changes.
REQ-011 i_data_mem  in  BITS_SIZE  data-memory word at o_select_addr_memdata, valid one cycle after the address changes.
REQ-012 i_tx_done  in  1  UART transmitter finished the current frame (one-cycle pulse).
REQ-013 o_tx_start  out  1  one-cycle pulse launching a UART frame.
REQ-014 o_tx_data  out  SIZE_TRAMA  frame byte, stable from o_tx_start until i_tx_done.
REQ-015 o_select_addr_registers  out  clog2(N_REGS)  register index being read.
REQ-016 o_select_addr_memdata  out  BITS_SIZE  data-memory word index being read.
REQ-017 o_busy  out  1  high from the cycle after accepted i_start until o_done.
REQ-018 o_done  out  1  one-cycle pulse after the last byte's i_tx_done.

Function
REQ-019 Dump order SHALL be: PC, cycle count, registers 0..N_REGS-1, memory words 0..SIZE_MEM_DATA-1; each word sent as BITS_SIZE/SIZE_TRAMA bytes, most-significant byte first.
REQ-020 Default total SHALL be (2+32+16)*4 = 200 frames per dump.
REQ-021 States SHALL be IDLE, SET_ADDR, LATCH, SEND, WAIT_TX, NEXT, FINISH.
REQ-022 IDLE->SET_ADDR on i_start; section=PC, word index=0, byte index=0.
REQ-023 SET_ADDR drives the selected address; LATCH (next cycle) captures the source word into a shift register; PC and cycle count are captured in LATCH as well.
REQ-024 SEND asserts o_tx_start for exactly one cycle with o_tx_data = top byte of the shift register, then enters WAIT_TX.
REQ-025 WAIT_TX holds o_tx_data until i_tx_done, then NEXT.
REQ-026 NEXT: if bytes remain in the word, shift left by SIZE_TRAMA and go to SEND; else advance word index (wrapping to 0 and advancing section at section end) and go to SET_ADDR; after the last memory word go to FINISH.
REQ-027 FINISH pulses o_done for one cycle, clears o_busy, returns to IDLE.
REQ-028 i_start while not IDLE SHALL be ignored; i_tx_done outside WAIT_TX SHALL be ignored.
REQ-029 Address outputs SHALL hold their last value outside their section and reset to 0.
REQ-030 Word and byte counters SHALL never exceed their section limits; no out-of-range address SHALL be driven.

Reset
REQ-031 On i_reset=0 at a clock edge: state IDLE, o_tx_start=0, o_tx_data=0, both address outputs 0, o_busy=0, o_done=0, all counters and the shift register 0.
REQ-032 Reset mid-dump SHALL abort without emitting further o_tx_start; the next i_start restarts from the PC.

Structure
REQ-033 State encoding, section encoding, and bytes-per-word constant SHALL live in the shared debug package used by the debug unit.
REQ-034 Byte serialisation (shift register + byte counter) MAY be one sub-module, word_serializer; everything else is in dump_sequencer.

Verification
REQ-035 Reset, then i_start with PC=0x00000010, count=0x0000002A, TX model answering i_tx_done 10 cycles after o_tx_start -> first 8 bytes 00 00 00 10 00 00 00 2A.
REQ-036 Register model R[k]=0x11110000+k -> bytes 9..12 = 11 11 00 00, bytes 133..136 = 11 11 00 1F; o_select_addr_registers steps 0..31.
REQ-037 Memory model M[k]=0xA0000000|k -> last 4 bytes A0 00 00 0F; o_done one pulse after the 200th i_tx_done; exactly 200 o_tx_start pulses.
REQ-038 i_start re-pulsed at byte 50, spurious i_tx_done while in SEND -> ignored; sequence and count unchanged.
REQ-039 i_reset=0 during byte 70 -> next cycle o_busy=0 and no o_tx_start; new i_start yields PC bytes first.
